cpu_run_ctrl: RTL and testbench

//  Synthesizable run/debug controller that sits between a host (UART/switch logic) and the

---
 rtl/cpu_run_ctrl_pkg.sv | 33 +++
 rtl/cpu_run_ctrl_if.sv | 29 ++
 rtl/cpu_run_ctrl_bp_match.sv | 53 +++++
 rtl/cpu_run_ctrl.sv | 166 ++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types and constants for the run/debug controller.
//   state_e      : controller FSM states
//   cmd_op_e     : host command encodings carried on cmd_op
//   halt_cause_e : reason reported on halt_cause while halted
//   HALT_INSTR_DEF : ARM "B ." encoding used as the program-end marker
package cpu_run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RST_HOLD = 2'd0,
        ST_HALTED   = 2'd1,
        ST_RUN      = 2'd2,
        ST_STEP     = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OP_RUN   = 2'd0,
        OP_STEP  = 2'd1,
        OP_HALT  = 2'd2,
        OP_RESET = 2'd3
    } cmd_op_e;

    typedef enum logic [2:0] {
        CAUSE_RESET     = 3'd0,
        CAUSE_HOST      = 3'd1,
        CAUSE_STEP_DONE = 3'd2,
        CAUSE_BREAK     = 3'd3,
        CAUSE_SELF_LOOP = 3'd4,
        CAUSE_TIMEOUT   = 3'd5
    } halt_cause_e;

    localparam logic [31:0] HALT_INSTR_DEF = 32'hEAFF_FFFE;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Host-side bus of the run controller: command handshake plus breakpoint writes.
//   cmd_valid/cmd_ready : command strobe, accepted when both are high
//   cmd_op/cmd_arg      : command code and STEP count
//   bp_wr/bp_idx        : breakpoint slot write strobe and slot index
//   bp_addr/bp_en       : breakpoint PC and enable written into the slot
// master = host, slave = controller.
interface cpu_run_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [CNT_W-1:0]  cmd_arg;
    logic              bp_wr;
    logic [2:0]        bp_idx;
    logic [ADDR_W-1:0] bp_addr;
    logic              bp_en;

    modport master (
        output cmd_valid, cmd_op, cmd_arg, bp_wr, bp_idx, bp_addr, bp_en,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, bp_wr, bp_idx, bp_addr, bp_en,
        output cmd_ready
    );
endinterface

// File: rtl/cpu_run_ctrl_bp_match.sv
// Breakpoint slots with parallel PC comparators.
//   clk, rst_n        : clock, async active-low reset (clears slot enables)
//   wr, idx           : write strobe and slot index (idx >= NUM_BP ignored)
//   wr_addr, wr_en    : PC and enable stored in the addressed slot
//   pc                : core PC compared against every slot
//   hit               : some enabled slot holds pc (uses registered slot values)
module cpu_run_ctrl_bp_match #(
    parameter int ADDR_W = 32,
    parameter int NUM_BP = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic [2:0]        idx,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] pc,
    output logic              hit
);

    logic [ADDR_W-1:0] slot_addr [NUM_BP];
    logic [NUM_BP-1:0] slot_en;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_en <= '0;
        end else begin
            for (int i = 0; i < NUM_BP; i++) begin
                if (wr && idx == 3'(i)) slot_en[i] <= wr_en;
            end
        end
    end

    // NOTE: the address array is not reset; a slot's address is only
    // observed through its enable bit, which is reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_BP; i++) begin
            if (wr && idx == 3'(i)) slot_addr[i] <= wr_addr;
        end
    end

    // NOTE: combinational outputs get a default before any condition so no
    // path leaves them unassigned (which would infer a latch).
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < NUM_BP; i++) begin
            if (slot_en[i] && slot_addr[i] == pc) hit = 1'b1;
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/debug controller for the single-cycle ARM core. Gates core execution
// via cpu_en, owns the core reset, and stops on host halt, step completion,
// PC breakpoints, branch-to-self and a RUN timeout.
//   clk, rst_n             : clock, async active-low reset
//   bus (slave)            : host commands and breakpoint writes
//   pc, instr              : core's current PC and instruction
//   cpu_en                 : core state-update enable (combinational)
//   cpu_rst_n              : core reset (registered)
//   halted, halt_cause     : halted flag and reason (registered)
//   cycle_cnt, instr_cnt   : saturating enabled-cycle / retired counters
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int               ADDR_W     = 32,
    parameter int               NUM_BP     = 2,
    parameter int               CNT_W      = 32,
    parameter int               RST_CYCLES = 4,
    parameter logic [CNT_W-1:0] MAX_CYCLES = CNT_W'(1000000),
    parameter logic [31:0]      HALT_INSTR = HALT_INSTR_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    cpu_run_ctrl_if.slave     bus,
    input  logic [ADDR_W-1:0] pc,
    input  logic [31:0]       instr,
    output logic              cpu_en,
    output logic              cpu_rst_n,
    output logic              halted,
    output logic [2:0]        halt_cause,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  instr_cnt
);

    localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    state_e           state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [CNT_W-1:0] step_left;
    logic             resume;     // first active cycle after leaving HALTED
    logic             bp_hit;

    logic             accept;
    logic             rst_cmd;
    logic             host_cmd;
    logic             stop;
    halt_cause_e      stop_cause;

    cpu_run_ctrl_bp_match #(
        .ADDR_W (ADDR_W),
        .NUM_BP (NUM_BP)
    ) u_bp_match (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr      (bus.bp_wr),
        .idx     (bus.bp_idx),
        .wr_addr (bus.bp_addr),
        .wr_en   (bus.bp_en),
        .pc      (pc),
        .hit     (bp_hit)
    );

    // Halt evaluation on the current pc/instr, highest priority first.
    // Breakpoints are masked on the resume cycle so a halt at a breakpoint
    // PC can step past it; the self-loop check is never masked.
    always_comb begin
        accept     = bus.cmd_valid && bus.cmd_ready;
        rst_cmd    = accept && (cmd_op_e'(bus.cmd_op) == OP_RESET);
        host_cmd   = accept && (cmd_op_e'(bus.cmd_op) == OP_HALT);
        stop       = 1'b1;
        stop_cause = CAUSE_RESET;
        if (rst_cmd) begin
            stop_cause = CAUSE_RESET;
        end else if (bp_hit && !resume) begin
            stop_cause = CAUSE_BREAK;
        end else if (instr == HALT_INSTR) begin
            stop_cause = CAUSE_SELF_LOOP;
        end else if (host_cmd) begin
            stop_cause = CAUSE_HOST;
        end else if (state == ST_RUN && MAX_CYCLES != '0 && cycle_cnt == MAX_CYCLES) begin
            stop_cause = CAUSE_TIMEOUT;
        end else begin
            stop = 1'b0;
        end
        cpu_en = (state == ST_RUN || state == ST_STEP) && !stop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_RST_HOLD;
            hold_cnt      <= '0;
            step_left     <= '0;
            resume        <= 1'b0;
            cpu_rst_n     <= 1'b0;
            bus.cmd_ready <= 1'b0;
            halted        <= 1'b0;
            halt_cause    <= CAUSE_RESET;
            cycle_cnt     <= '0;
            instr_cnt     <= '0;
        end else begin
            resume <= (state == ST_HALTED);
            if (rst_cmd) begin
                // Core reset again; breakpoint slots are left untouched.
                state         <= ST_RST_HOLD;
                hold_cnt      <= '0;
                cpu_rst_n     <= 1'b0;
                bus.cmd_ready <= 1'b0;
                halted        <= 1'b0;
                halt_cause    <= CAUSE_RESET;
                cycle_cnt     <= '0;
                instr_cnt     <= '0;
            end else begin
                unique case (state)
                    ST_RST_HOLD: begin
                        if (hold_cnt == HOLD_W'(RST_CYCLES - 1)) begin
                            state         <= ST_HALTED;
                            cpu_rst_n     <= 1'b1;
                            bus.cmd_ready <= 1'b1;
                            halted        <= 1'b1;
                            halt_cause    <= CAUSE_RESET;
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                    ST_HALTED: begin
                        if (accept) begin
                            unique case (cmd_op_e'(bus.cmd_op))
                                OP_RUN: begin
                                    state  <= ST_RUN;
                                    halted <= 1'b0;
                                end
                                OP_STEP: begin
                                    if (bus.cmd_arg != '0) begin
                                        state     <= ST_STEP;
                                        step_left <= bus.cmd_arg;
                                        halted    <= 1'b0;
                                    end
                                end
                                OP_HALT:  ;
                                OP_RESET: ;
                            endcase
                        end
                    end
                    default: begin
                        if (stop) begin
                            state      <= ST_HALTED;
                            halted     <= 1'b1;
                            halt_cause <= stop_cause;
                        end else begin
                            if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + CNT_W'(1);
                            if (instr_cnt != '1) instr_cnt <= instr_cnt + CNT_W'(1);
                            if (state == ST_STEP) begin
                                step_left <= step_left - CNT_W'(1);
                                if (step_left == CNT_W'(1)) begin
                                    state      <= ST_HALTED;
                                    halted     <= 1'b1;
                                    halt_cause <= CAUSE_STEP_DONE;
                                end
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl. A tiny core model advances pc on
// cpu_en; expected halt results are queued when a command is issued and
// compared when the controller reports halted.
module tb_cpu_run_ctrl;

    localparam logic [1:0] RUN = 2'd0, STEP = 2'd1, HALT = 2'd2, RESET = 2'd3;
    localparam logic [31:0] NOP = 32'hE1A0_0000;
    localparam logic [31:0] BSELF = 32'hEAFF_FFFE;

    typedef struct {
        logic [2:0]  cause;
        logic [31:0] icnt;
        logic [31:0] ccnt;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] instr;
    logic        cpu_en, cpu_rst_n, halted;
    logic [2:0]  halt_cause;
    logic [31:0] cycle_cnt, instr_cnt;

    logic        loop_mode = 1'b0;   // pc 0x08 branches back to 0x00
    logic        halt_at_en = 1'b0;  // branch-to-self placed at 0x20
    int          pulses = 0;

    int          checks = 0;
    int          failures = 0;
    exp_t        sb[$];

    cpu_run_ctrl_if #(.ADDR_W(32), .CNT_W(32)) bus ();

    cpu_run_ctrl #(
        .ADDR_W     (32),
        .NUM_BP     (2),
        .CNT_W      (32),
        .RST_CYCLES (4),
        .MAX_CYCLES (32'd16),
        .HALT_INSTR (BSELF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .pc         (pc),
        .instr      (instr),
        .cpu_en     (cpu_en),
        .cpu_rst_n  (cpu_rst_n),
        .halted     (halted),
        .halt_cause (halt_cause),
        .cycle_cnt  (cycle_cnt),
        .instr_cnt  (instr_cnt)
    );

    always #5 clk = ~clk;

    assign instr = (halt_at_en && pc == 32'h20) ? BSELF : NOP;

    // Core model: one instruction retires per enabled cycle.
    always @(posedge clk) begin
        if (!cpu_rst_n) begin
            pc <= '0;
        end else if (cpu_en) begin
            pc     <= (loop_mode && pc == 32'h08) ? 32'h0 : pc + 32'd4;
            pulses <= pulses + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called right after a negedge; holds the command for one clock.
    task automatic send_cmd(input logic [1:0] op, input logic [31:0] arg);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_arg   = arg;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic bp_write(input logic [2:0] idx, input logic [31:0] addr, input logic en);
        bus.bp_wr   = 1'b1;
        bus.bp_idx  = idx;
        bus.bp_addr = addr;
        bus.bp_en   = en;
        @(negedge clk);
        bus.bp_wr   = 1'b0;
    endtask

    task automatic expect_halt(input logic [2:0] cause, input logic [31:0] icnt,
                               input logic [31:0] ccnt, input logic [31:0] pcv);
        exp_t e;
        e.cause = cause; e.icnt = icnt; e.ccnt = ccnt; e.pc = pcv;
        sb.push_back(e);
    endtask

    task automatic wait_halt(input string tag);
        exp_t e;
        int   n;
        n = 0;
        while (!halted && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_halted"}, {31'd0, halted}, 32'd1);
        e = sb.pop_front();
        if (halted) begin
            check({tag, "_cause"}, {29'd0, halt_cause}, {29'd0, e.cause});
            check({tag, "_instr_cnt"}, instr_cnt, e.icnt);
            check({tag, "_cycle_cnt"}, cycle_cnt, e.ccnt);
            check({tag, "_pc"}, pc, e.pc);
            check({tag, "_ready"}, {31'd0, bus.cmd_ready}, 32'd1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int p0;
        bus.cmd_valid = 1'b0; bus.cmd_op = RUN; bus.cmd_arg = '0;
        bus.bp_wr = 1'b0; bus.bp_idx = '0; bus.bp_addr = '0; bus.bp_en = 1'b0;

        // Reset values while RST_N is low.
        repeat (3) @(negedge clk);
        check("rst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        check("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_ready", {31'd0, bus.cmd_ready}, 32'd0);
        check("rst_cycle_cnt", cycle_cnt, 32'd0);
        rst_n = 1'b1;
        n = 0;
        while (!cpu_rst_n && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rst_hold_len", n, 32'd4);
        expect_halt(3'd0, 32'd0, 32'd0, 32'h0);
        wait_halt("reset");

        // STEP 5 retires exactly five instructions.
        p0 = pulses;
        expect_halt(3'd2, 32'd5, 32'd5, 32'h14);
        send_cmd(STEP, 32'd5);
        wait_halt("step5");
        check("step5_pulses", pulses - p0, 32'd5);

        // STEP 0 is a no-op.
        send_cmd(STEP, 32'd0);
        repeat (3) @(negedge clk);
        check("step0_halted", {31'd0, halted}, 32'd1);
        check("step0_instr_cnt", instr_cnt, 32'd5);

        expect_halt(3'd0, 32'd0, 32'd0, 32'h0);
        send_cmd(RESET, 32'd0);
        wait_halt("rst_cmd1");

        // Breakpoints: slot0 live, slot1 disabled, slot5 out of range.
        bp_write(3'd0, 32'h10, 1'b1);
        bp_write(3'd1, 32'h0C, 1'b0);
        bp_write(3'd5, 32'h08, 1'b1);

        // HOST halt in the same cycle as the breakpoint: BREAK wins.
        expect_halt(3'd3, 32'd4, 32'd4, 32'h10);
        send_cmd(RUN, 32'd0);
        n = 0;
        while (pc != 32'h10 && n < 40) begin
            @(negedge clk);
            n++;
        end
        send_cmd(HALT, 32'd0);
        wait_halt("bp_and_halt");

        // Resume skips the breakpoint at the current PC and runs to timeout.
        expect_halt(3'd5, 32'd16, 32'd16, 32'h40);
        send_cmd(RUN, 32'd0);
        wait_halt("resume_timeout");

        // RESET during RUN clears counters, keeps breakpoints.
        expect_halt(3'd0, 32'd0, 32'd0, 32'h0);
        send_cmd(RESET, 32'd0);
        wait_halt("rst_cmd2");
        send_cmd(RUN, 32'd0);
        repeat (2) @(negedge clk);
        send_cmd(RESET, 32'd0);
        check("runrst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        check("runrst_cycle_cnt", cycle_cnt, 32'd0);
        check("runrst_halted", {31'd0, halted}, 32'd0);
        expect_halt(3'd0, 32'd0, 32'd0, 32'h0);
        wait_halt("runrst");
        expect_halt(3'd3, 32'd4, 32'd4, 32'h10);
        send_cmd(RUN, 32'd0);
        wait_halt("bp_kept");

        // Branch-to-self at 0x20 halts, and is never skipped on resume.
        bp_write(3'd0, 32'h10, 1'b0);
        expect_halt(3'd0, 32'd0, 32'd0, 32'h0);
        send_cmd(RESET, 32'd0);
        wait_halt("rst_cmd3");
        halt_at_en = 1'b1;
        expect_halt(3'd4, 32'd8, 32'd8, 32'h20);
        send_cmd(RUN, 32'd0);
        wait_halt("self_loop");
        expect_halt(3'd4, 32'd8, 32'd8, 32'h20);
        send_cmd(RUN, 32'd0);
        wait_halt("self_loop_again");
        halt_at_en = 1'b0;

        // Host halt after two retired instructions.
        expect_halt(3'd0, 32'd0, 32'd0, 32'h0);
        send_cmd(RESET, 32'd0);
        wait_halt("rst_cmd4");
        expect_halt(3'd1, 32'd2, 32'd2, 32'h08);
        send_cmd(RUN, 32'd0);
        repeat (2) @(negedge clk);
        send_cmd(HALT, 32'd0);
        wait_halt("host");

        // Timeout on a loop that never reaches the self-branch.
        expect_halt(3'd0, 32'd0, 32'd0, 32'h0);
        send_cmd(RESET, 32'd0);
        wait_halt("rst_cmd5");
        loop_mode = 1'b1;
        expect_halt(3'd5, 32'd16, 32'd16, 32'h04);
        send_cmd(RUN, 32'd0);
        wait_halt("loop_timeout");

        // Asynchronous reset mid-run stops the core immediately.
        expect_halt(3'd0, 32'd0, 32'd0, 32'h0);
        send_cmd(RESET, 32'd0);
        wait_halt("rst_cmd6");
        send_cmd(RUN, 32'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_cpu_en", {31'd0, cpu_en}, 32'd0);
        check("arst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        check("arst_cycle_cnt", cycle_cnt, 32'd0);
        check("arst_ready", {31'd0, bus.cmd_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        expect_halt(3'd0, 32'd0, 32'd0, 32'h0);
        wait_halt("arst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
